spm_mem_dump: RTL and testbench

Read-side counterpart to the program/data loader for RISC_SPM's Memory_Unit. After a run, it reads a contiguous range of SRAM words, such as results or the program image. It streams them out one word at a time over a valid/ready handshake, for a bench checker or a host link. It is the bus master on the memory read port while busy; the CPU must be halted or held off the port during a dump.

---
 rtl/spm_mem_dump_if.sv | 29 ++
 rtl/spm_mem_dump.sv | 77 +++++++
 tb/tb_spm_mem_dump.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spm_mem_dump_if.sv
// Bus bundle for spm_mem_dump: control request, SRAM read port and the
// valid/ready output stream. master = the dump engine, slave = its surroundings.
interface spm_mem_dump_if #(
  parameter int word_size = 8,
  parameter int addr_size = 8
);
  logic                 start;
  logic [addr_size-1:0] base_addr;
  logic [addr_size:0]   count;
  logic [addr_size-1:0] mem_addr;
  logic                 mem_rd;
  logic [word_size-1:0] mem_data;
  logic [word_size-1:0] dout;
  logic                 dout_valid;
  logic                 dout_ready;
  logic                 dout_last;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, base_addr, count, mem_data, dout_ready,
    output mem_addr, mem_rd, dout, dout_valid, dout_last, busy, done
  );

  modport slave (
    output start, base_addr, count, mem_data, dout_ready,
    input  mem_addr, mem_rd, dout, dout_valid, dout_last, busy, done
  );
endinterface

// File: rtl/spm_mem_dump.sv
// Reads a contiguous SRAM range and streams it out one word per valid/ready
// transfer; owns the memory read port while busy.
module spm_mem_dump #(
  parameter int word_size = 8,
  parameter int addr_size = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  spm_mem_dump_if.master        bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [addr_size-1:0] ADDR_INC = addr_size'(1);
  localparam logic [addr_size:0]   REM_ONE  = (addr_size + 1)'(1);

  logic [1:0]           state;
  logic [addr_size-1:0] addr_reg;
  logic [addr_size:0]   remaining;
  logic [word_size-1:0] dout_reg;
  logic                 valid_reg;
  logic                 last_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_reg  <= '0;
      remaining <= '0;
      dout_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.count != '0) begin
              addr_reg  <= bus.base_addr;
              remaining <= bus.count;
              state     <= FETCH;
            end else begin
              state <= DONE;
            end
          end
        end
        FETCH: begin
          dout_reg  <= bus.mem_data;
          valid_reg <= 1'b1;
          last_reg  <= (remaining == REM_ONE);
          state     <= SEND;
        end
        SEND: begin
          // remaining is at least 1 here, so the decrement cannot underflow
          if (bus.dout_ready) begin
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            addr_reg  <= addr_reg + ADDR_INC;
            remaining <= remaining - REM_ONE;
            state     <= (remaining == REM_ONE) ? DONE : FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr   = (state == IDLE) ? '0 : addr_reg;
  assign bus.mem_rd     = (state == FETCH);
  assign bus.dout       = dout_reg;
  assign bus.dout_valid = valid_reg;
  assign bus.dout_last  = last_reg;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_spm_mem_dump.sv
// Self-checking bench for spm_mem_dump: transaction-level model of the dump
// (expected address/word queue) checked every cycle, plus directed scenarios.
module tb_spm_mem_dump;

  typedef struct {
    logic [7:0] addr;
    logic       last;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spm_mem_dump_if #(.word_size(8), .addr_size(8)) bus ();

  spm_mem_dump #(.word_size(8), .addr_size(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [256];
  assign bus.mem_data = mem[bus.mem_addr];

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_reset_outputs(string tag);
    chk({tag, ".mem_addr"},   32'(bus.mem_addr),   32'd0);
    chk({tag, ".mem_rd"},     32'(bus.mem_rd),     32'd0);
    chk({tag, ".dout"},       32'(bus.dout),       32'd0);
    chk({tag, ".dout_valid"}, 32'(bus.dout_valid), 32'd0);
    chk({tag, ".dout_last"},  32'(bus.dout_last),  32'd0);
    chk({tag, ".busy"},       32'(bus.busy),       32'd0);
    chk({tag, ".done"},       32'(bus.done),       32'd0);
  endfunction

  // Reference model: a dump is just a list of (address, is-last) pairs.
  item_t      expq[$];
  bit         fetched   = 0;
  bit         done_next = 0;
  bit         busy_exp  = 0;
  logic [7:0] log_data[$];
  bit         log_last[$];
  int         log_cyc[$];
  logic [7:0] rd_log[$];
  int         done_cnt  = 0;
  int         done_cyc  = 0;

  always @(negedge clk) begin
    bit exp_rd;
    if (!rst) begin
      chk_reset_outputs("rst");
      expq.delete();
      fetched   = 0;
      done_next = 0;
      busy_exp  = 0;
    end else begin
      chk("busy", 32'(bus.busy), 32'(busy_exp));
      chk("done", 32'(bus.done), 32'(done_next));
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      done_next = 0;
      exp_rd = (expq.size() != 0) && !fetched;
      chk("mem_rd", 32'(bus.mem_rd), 32'(exp_rd));
      chk("dout_valid", 32'(bus.dout_valid), 32'(fetched && expq.size() != 0));
      if (expq.size() != 0) chk("mem_addr", 32'(bus.mem_addr), 32'(expq[0].addr));
      if (bus.mem_rd) rd_log.push_back(bus.mem_addr);
      if (exp_rd) begin
        fetched = 1;
      end else if (expq.size() != 0) begin
        chk("dout", 32'(bus.dout), 32'(mem[expq[0].addr]));
        chk("dout_last", 32'(bus.dout_last), 32'(expq[0].last));
        if (bus.dout_ready) begin
          log_data.push_back(bus.dout);
          log_last.push_back(bus.dout_last);
          log_cyc.push_back(cyc);
          if (expq[0].last) done_next = 1;
          void'(expq.pop_front());
          fetched = 0;
        end
      end
      if (bus.start && !bus.busy) begin
        if (bus.count == 9'd0) begin
          done_next = 1;
        end else begin
          for (int i = 0; i < int'(bus.count); i++) begin
            item_t it;
            it.addr = 8'((int'(bus.base_addr) + i) % 256);
            it.last = (i == int'(bus.count) - 1);
            expq.push_back(it);
          end
        end
      end
      busy_exp = (expq.size() != 0) || done_next;
    end
  end

  // Sink: always ready, random, or stalled 3 cycles on one chosen word.
  bit rand_ready = 0;
  int stall_word = -1;
  int stalled    = 0;
  always @(posedge clk) begin
    #1;
    if (log_data.size() == stall_word && bus.dout_valid && stalled < 3) begin
      bus.dout_ready = 1'b0;
      stalled++;
    end else begin
      if (log_data.size() != stall_word) stalled = 0;
      bus.dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic start_dump(input logic [7:0] b, input logic [8:0] c);
    @(posedge clk); #1;
    bus.base_addr = b;
    bus.count     = c;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((bus.busy || expq.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_idle_in_budget", 32'(n < budget), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_stream(string tag, int base, input logic [7:0] exp_w[$]);
    chk({tag, ".words"}, 32'(log_data.size() - base), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && base + i < log_data.size(); i++) begin
      chk({tag, ".data"}, 32'(log_data[base + i]), 32'(exp_w[i]));
      chk({tag, ".last"}, 32'(log_last[base + i]), 32'(i == exp_w.size() - 1));
    end
  endtask

  initial begin
    int base, dc;
    logic [7:0] exp_w[$];

    bus.start = 1'b0; bus.base_addr = '0; bus.count = '0; bus.dout_ready = 1'b1;
    for (int k = 0; k < 256; k++) mem[k] = 8'(k);
    mem[128] = 8'd6; mem[129] = 8'd1; mem[130] = 8'd2; mem[131] = 8'd0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("init");
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // 1: basic 4-word dump with continuous ready
    base = log_data.size(); dc = done_cnt;
    start_dump(8'd128, 9'd4);
    wait_idle(50);
    exp_w = '{8'd6, 8'd1, 8'd2, 8'd0};
    check_stream("s1", base, exp_w);
    if (log_cyc.size() >= 4) begin
      for (int i = 1; i < 4; i++)
        chk("s1.spacing", 32'(log_cyc[base + i] - log_cyc[base + i - 1]), 32'd2);
      chk("s1.done_after_last", 32'(done_cyc - log_cyc[base + 3]), 32'd1);
    end
    chk("s1.done_once", 32'(done_cnt - dc), 32'd1);

    // 2: stall the second word for 3 cycles
    base = log_data.size(); dc = done_cnt;
    stall_word = base + 1;
    start_dump(8'd128, 9'd4);
    wait_idle(50);
    stall_word = -1;
    check_stream("s2", base, exp_w);
    if (log_cyc.size() >= base + 2)
      chk("s2.stall_gap", 32'(log_cyc[base + 1] - log_cyc[base]), 32'd5);
    chk("s2.done_once", 32'(done_cnt - dc), 32'd1);

    // 3: address wrap 254 -> 255 -> 0
    mem[254] = 8'hAA; mem[255] = 8'hF0; mem[0] = 8'h00;
    base = log_data.size(); rd_log.delete();
    start_dump(8'd254, 9'd3);
    wait_idle(50);
    exp_w = '{8'hAA, 8'hF0, 8'h00};
    check_stream("s3", base, exp_w);
    chk("s3.reads", 32'(rd_log.size()), 32'd3);
    if (rd_log.size() == 3) begin
      chk("s3.addr0", 32'(rd_log[0]), 32'd254);
      chk("s3.addr1", 32'(rd_log[1]), 32'd255);
      chk("s3.addr2", 32'(rd_log[2]), 32'd0);
    end

    // 4: zero-length dump
    base = log_data.size(); dc = done_cnt;
    start_dump(8'd5, 9'd0);
    wait_idle(20);
    chk("s4.no_words", 32'(log_data.size() - base), 32'd0);
    chk("s4.done_once", 32'(done_cnt - dc), 32'd1);

    // 5: whole memory, with an ignored start mid-dump
    for (int k = 0; k < 256; k++) mem[k] = 8'(k);
    base = log_data.size(); dc = done_cnt;
    start_dump(8'd0, 9'd256);
    repeat (100) @(posedge clk);
    #1 bus.base_addr = 8'd9; bus.count = 9'd2; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_idle(700);
    exp_w.delete();
    for (int k = 0; k < 256; k++) exp_w.push_back(8'(k));
    check_stream("s5", base, exp_w);
    chk("s5.done_once", 32'(done_cnt - dc), 32'd1);

    // 6: async reset during SEND of word 2, then a one-word dump
    mem[128] = 8'd6; mem[129] = 8'd1; mem[130] = 8'd2; mem[131] = 8'd0;
    base = log_data.size(); dc = done_cnt;
    start_dump(8'd128, 9'd4);
    begin
      int n = 0;
      while (!(log_data.size() == base + 1 && bus.dout_valid) && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      chk("s6.reach_word2", 32'(n < 40), 32'd1);
    end
    #2 rst = 1'b0;
    #1 chk_reset_outputs("s6.async");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("s6.no_done", 32'(done_cnt - dc), 32'd0);
    chk("s6.words_before_reset", 32'(log_data.size() - base), 32'd1);
    base = log_data.size();
    start_dump(8'd128, 9'd1);
    wait_idle(20);
    exp_w = '{8'd6};
    check_stream("s6.after", base, exp_w);

    // Random dumps against the model, with random sink back-pressure
    rand_ready = 1;
    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
      dc = done_cnt; base = log_data.size();
      begin
        int c;
        c = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 24));
        start_dump(8'($urandom), 9'(c));
        wait_idle(400);
        chk("rand.words", 32'(log_data.size() - base), 32'(c));
        chk("rand.done_once", 32'(done_cnt - dc), 32'd1);
      end
    end
    rand_ready = 0;

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
